line_fb_writer: RTL
===================

Name: line_fb_writer

Overview:
Sink for the pixel stream produced by line_gen. It accepts (x,y) line pixels through a valid/ready handshake and buffers them in a small FIFO. It converts each pixel to a linear frame-buffer address and issues single-cycle BRAM writes. On each frame start it clears the whole buffer before drawing resumes, so the HDMI side reads freshly drawn wireframes.

Parameters:
H_ACTIVE, 1280, active pixels per line; valid x range is 0..H_ACTIVE-1.
V_ACTIVE, 720, active lines per frame; valid y range is 0..V_ACTIVE-1.
FIFO_DEPTH, 16, pixel FIFO entries; must be a power of 2 and at least 2.
PIXEL_W, 8, frame-buffer data width.
ADDR_W, 20, frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
clk_in  input  1  system clock.
rst_in  input  1  asynchronous, active-high reset.
x_in  input  11  pixel x from line_gen.
y_in  input  10  pixel y from line_gen.
color_in  input  PIXEL_W  draw colour, sampled with each accepted pixel.
pixel_valid_in  input  1  x_in, y_in and color_in are valid.
pixel_ready_out  output  1  block can accept a pixel this cycle.
frame_start_in  input  1  single-cycle pulse requesting a clear and a new frame.
clear_busy_out  output  1  high while in CLEAR.
fb_addr_out  output  ADDR_W  BRAM write address.
fb_data_out  output  PIXEL_W  BRAM write data.
fb_we_out  output  1  BRAM write enable.
drop_count_out  output  16  saturating count of rejected out-of-range pixels.

Behaviour:
- Reset values:
  - State is IDLE and the FIFO is empty.
  - All outputs are 0: pixel_ready_out, clear_busy_out, fb_we_out, fb_addr_out, fb_data_out, drop_count_out.
- FSM states: IDLE, CLEAR, DRAW.
- Transitions:
  - IDLE to CLEAR when frame_start_in is high.
  - CLEAR to DRAW after the write to address H_ACTIVE*V_ACTIVE-1.
  - DRAW to CLEAR when frame_start_in is high.
  - DRAW has no other exit.
- CLEAR:
  - One write per cycle: fb_we_out=1, fb_data_out=0, fb_addr_out counts 0..H_ACTIVE*V_ACTIVE-1.
  - CLEAR lasts exactly H_ACTIVE*V_ACTIVE cycles.
  - frame_start_in during CLEAR restarts the counter at 0.
  - pixel_ready_out=0 throughout.
- pixel_ready_out is combinational: (state==DRAW) && !fifo_full && !frame_start_in.
  - A frame_start_in pulse therefore never coincides with a completed handshake.
- Handshake completes on pixel_valid_in && pixel_ready_out at the rising edge.
  - If x_in>=H_ACTIVE or y_in>=V_ACTIVE, the pixel is consumed but not stored; drop_count_out increments and saturates at 16'hFFFF.
  - drop_count_out clears only on reset.
- FIFO: a push takes one cycle to become visible to the pop side.
  - Simultaneous push and pop while full is impossible, because ready is low when full.
  - Simultaneous push and pop while empty is legal: the new entry is popped on the next cycle.
- Write stage (DRAW only): when the FIFO is non-empty, pop one entry per cycle.
  - The address y*H_ACTIVE+x, computed at ADDR_W width, is registered together with the colour.
  - fb_we_out pulses 1 on the following cycle.
- Latency: pixel accepted at edge k produces fb_we_out=1 during the cycle after edge k+2, with the FIFO previously empty.
- Sustained throughput: 1 pixel/cycle.
- frame_start_in in DRAW:
  - The FIFO is flushed and its contents discarded.
  - Any write-stage entry already registered still completes its fb_we_out pulse on that cycle.
  - CLEAR starts on the next cycle.
- fb_we_out is 0 in IDLE and whenever the write stage has nothing to write.

Optional Feature:
LINE_FB_DEDUP_EN
- Defined: a FIFO entry whose (x,y) equals the last written address in DRAW is popped without asserting fb_we_out.
  - The last-address register invalidates on entering CLEAR.
- Undefined: every in-range pixel is written, including duplicates.

Decomposition:
- Package line_fb_pkg holds:
  - H_ACTIVE and V_ACTIVE defaults.
  - The fb_state_t enum {IDLE, CLEAR, DRAW}.
  - The packed struct pixel_t {x[10:0], y[9:0], color[PIXEL_W-1:0]}.
- Sub-module pixel_fifo: synchronous FIFO of pixel_t with push, pop, flush, full and empty.

Test Plan:
- Reset, then pulse frame_start_in -> clear_busy_out high for exactly 921600 cycles with sequential addresses and data 0, then DRAW with pixel_ready_out=1.
- After clear, stream (3,5),(8,2),(9,4) with color 8'hFF back-to-back -> writes to addresses 6403, 2568 and 5129 on consecutive cycles, the first in the cycle after edge k+2 (k = acceptance edge of (3,5)).
- Send (1280,0) and then (0,720) -> no fb_we_out and drop_count_out=2.
- Hold pixel_valid_in high while the write stage is forced idle by H_ACTIVE=4, V_ACTIVE=4 and a frame_start_in pulse -> pixel_ready_out low throughout the 16-cycle clear; no handshakes are lost.
- Fill the FIFO (16 entries) with frame_start_in pulsed mid-stream -> remaining entries are discarded, CLEAR restarts at address 0, and no stale writes occur after CLEAR.
- With LINE_FB_DEDUP_EN defined, send (3,5) twice in a row -> exactly one fb_we_out pulse.

Source files
------------

// File: rtl/line_fb_pkg.sv
// Shared types and defaults for the line frame-buffer writer.
package line_fb_pkg;

   localparam int unsigned H_ACTIVE_DEF = 1280;
   localparam int unsigned V_ACTIVE_DEF = 720;
   localparam int unsigned X_W          = 11;
   localparam int unsigned Y_W          = 10;
   localparam int unsigned COLOR_W      = 8;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      DRAW
   } fb_state_t;

   typedef struct packed {
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic [COLOR_W-1:0] color;
   } pixel_t;

   // Linear frame-buffer address y*h+x at full 32-bit width; callers truncate.
   function automatic logic [31:0] lin_addr(input logic [X_W-1:0] x,
                                            input logic [Y_W-1:0] y,
                                            input int unsigned h);
      return 32'(y) * h + 32'(x);
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO; a push becomes visible to the pop side one cycle later.
module pixel_fifo
   import line_fb_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  pixel_t din,
   input  logic   pop,
   input  logic   flush,
   output pixel_t dout,
   output logic   full,
   output logic   empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   pixel_t         mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic [AW:0]    wr_vis;

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
   end

   // wr_vis lags wr_ptr by one cycle so the reader sees a push one cycle late.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         wr_vis <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         wr_vis <= wr_ptr;
      end else begin
         if (push)           wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty)  rd_ptr <= rd_ptr + (AW+1)'(1);
         wr_vis <= wr_ptr;
      end
   end

   assign full  = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
   assign empty = (rd_ptr == wr_vis);
   assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/line_fb_writer.sv
// Pixel-stream sink: clears the frame buffer on frame start, then writes buffered pixels.
// Optional LINE_FB_DEDUP_EN suppresses repeated writes to the last written address.
module line_fb_writer
   import line_fb_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned PIXEL_W    = COLOR_W,
   parameter int unsigned ADDR_W     = 20
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [10:0]        x_in,
   input  logic [9:0]         y_in,
   input  logic [PIXEL_W-1:0] color_in,
   input  logic               pixel_valid_in,
   output logic               pixel_ready_out,
   input  logic               frame_start_in,
   output logic               clear_busy_out,
   output logic [ADDR_W-1:0]  fb_addr_out,
   output logic [PIXEL_W-1:0] fb_data_out,
   output logic               fb_we_out,
   output logic [15:0]        drop_count_out
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   fb_state_t          state;
   fb_state_t          state_nx;
   logic               we_nx;
   logic [ADDR_W-1:0]  addr_nx;
   logic [PIXEL_W-1:0] data_nx;

   logic               fifo_full;
   logic               fifo_empty;
   pixel_t             fifo_din;
   pixel_t             fifo_dout;
   logic               accept;
   logic               in_range;
   logic               push;
   logic               pop;
   logic               flush;
   logic               dup;
   logic [ADDR_W-1:0]  pop_addr;

   assign pixel_ready_out = (state == DRAW) && !fifo_full && !frame_start_in;
   assign accept          = pixel_valid_in && pixel_ready_out;
   assign in_range        = (32'(x_in) < H_ACTIVE) && (32'(y_in) < V_ACTIVE);
   assign push            = accept && in_range;
   assign flush           = (state == DRAW) && frame_start_in;
   assign pop             = (state == DRAW) && !fifo_empty && !frame_start_in;
   assign pop_addr        = ADDR_W'(lin_addr(fifo_dout.x, fifo_dout.y, H_ACTIVE));

   assign fifo_din.x      = x_in;
   assign fifo_din.y      = y_in;
   assign fifo_din.color  = COLOR_W'(color_in);

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_in),
      .rst   (rst_in),
      .push  (push),
      .din   (fifo_din),
      .pop   (pop),
      .flush (flush),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef LINE_FB_DEDUP_EN
   logic              last_v;
   logic [ADDR_W-1:0] last_addr;

   assign dup = last_v && (last_addr == pop_addr);

   // Tracks the address of the most recent draw write; forgotten on every clear.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         last_v    <= 1'b0;
         last_addr <= '0;
      end else if (state_nx == CLEAR) begin
         last_v    <= 1'b0;
      end else if (pop && !dup) begin
         last_v    <= 1'b1;
         last_addr <= pop_addr;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // Next state and next write-port values; the clear counter lives in fb_addr_out.
   always_comb begin
      state_nx = state;
      we_nx    = 1'b0;
      addr_nx  = fb_addr_out;
      data_nx  = fb_data_out;

      unique case (state)
         IDLE:    if (frame_start_in) state_nx = CLEAR;
         CLEAR:   if (!frame_start_in && (fb_addr_out == LAST_ADDR)) state_nx = DRAW;
         DRAW:    if (frame_start_in) state_nx = CLEAR;
         default: state_nx = IDLE;
      endcase

      if (state_nx == CLEAR) begin
         we_nx   = 1'b1;
         data_nx = '0;
         addr_nx = ((state == CLEAR) && !frame_start_in) ? fb_addr_out + ADDR_W'(1) : '0;
      end else if (pop && !dup) begin
         we_nx   = 1'b1;
         addr_nx = pop_addr;
         data_nx = PIXEL_W'(fifo_dout.color);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state          <= IDLE;
         clear_busy_out <= 1'b0;
         fb_we_out      <= 1'b0;
         fb_addr_out    <= '0;
         fb_data_out    <= '0;
         drop_count_out <= '0;
      end else begin
         state          <= state_nx;
         clear_busy_out <= (state_nx == CLEAR);
         fb_we_out      <= we_nx;
         fb_addr_out    <= addr_nx;
         fb_data_out    <= data_nx;
         if (accept && !in_range && (drop_count_out != 16'hFFFF))
            drop_count_out <= drop_count_out + 16'd1;
      end
   end

endmodule
